// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   fetch_state_t    - fetch FSM state encoding
//   NOP_INSTR        - instruction word presented while nothing has been fetched
//   DEFAULT_RESET_PC - default address shown on imem_addr when no request is live
//   misaligned()     - true when a PC is not word aligned
package fetch_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      REQ,
      WAIT,
      EXEC,
      FAULT
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

   function automatic logic misaligned(input logic [1:0] pc_lsb);
      return pc_lsb != 2'b00;
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: direct-mapped instruction buffer, one word per entry.
// Only built when FETCH_BUFFER_EN is defined.
//   clk, reset       - clock, asynchronous active-low reset (clears valid bits)
//   rd_addr          - word address (pc[31:2]) looked up combinationally
//   hit, rd_data     - lookup result for rd_addr
//   wr_en, wr_addr,
//   wr_data          - fill port, written at the clock edge
//   flush            - clears every valid bit at the next edge; beats a write
module fetch_buffer #(
   parameter int ENTRIES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:2] rd_addr,
   output logic        hit,
   output logic [31:0] rd_data,
   input  logic        wr_en,
   input  logic [31:2] wr_addr,
   input  logic [31:0] wr_data,
   input  logic        flush
);
   localparam int K  = $clog2(ENTRIES);
   localparam int TW = 32 - K - 2;

   logic [TW-1:0]      tag_q  [ENTRIES];
   logic [31:0]        data_q [ENTRIES];
   logic [ENTRIES-1:0] valid_q;

   logic [K-1:0] rd_idx;
   logic [K-1:0] wr_idx;

   assign rd_idx  = rd_addr[K+1:2];
   assign wr_idx  = wr_addr[K+1:2];
   assign hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_addr[31:K+2]);
   assign rd_data = data_q[rd_idx];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         valid_q <= '0;
      else if (flush)
         valid_q <= '0;
      else if (wr_en)
         valid_q[wr_idx] <= 1'b1;
   end

   // Tag/data need no reset: nothing is trusted until its valid bit is set.
   always_ff @(posedge clk) begin
      if (wr_en && !flush) begin
         tag_q[wr_idx]  <= wr_addr[31:K+2];
         data_q[wr_idx] <= wr_data;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of a single-cycle MIPS datapath.
// Fetches the word at pc through a req/gnt/rvalid memory handshake, then
// presents it on instr with a one-cycle enable pulse so the datapath executes
// it and advances pc. Misaligned pc parks the unit in a sticky fault state.
// Optional feature macro FETCH_BUFFER_EN adds a direct-mapped buffer
// (BUF_ENTRIES entries) consulted in a LOOKUP state before going to memory.
//   clk, reset        - clock, asynchronous active-low reset
//   pc                - current PC from the datapath
//   instr, enable     - registered instruction and advance strobe
//   imem_req/addr     - request valid / address (RESET_PC when idle)
//   imem_gnt          - request accepted this cycle
//   imem_rvalid/rdata - response; only accepted in WAIT
//   flush             - invalidate buffer (ignored without the macro)
//   fault             - sticky misaligned-PC flag
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int          BUF_ENTRIES = 4,
   parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   output logic [31:0] instr,
   output logic        enable,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        flush,
   output logic        fault
);
   fetch_state_t state_q, state_d;
   logic         load;
   logic [31:0]  load_data;
   logic         req;
   logic         buf_wr;

`ifdef FETCH_BUFFER_EN
   localparam fetch_state_t FIRST = LOOKUP;
   logic        buf_hit;
   logic [31:0] buf_data;

   fetch_buffer #(.ENTRIES(BUF_ENTRIES)) u_buf (
      .clk     (clk),
      .reset   (reset),
      .rd_addr (pc[31:2]),
      .hit     (buf_hit),
      .rd_data (buf_data),
      .wr_en   (buf_wr),
      .wr_addr (pc[31:2]),
      .wr_data (imem_rdata),
      .flush   (flush)
   );
`else
   localparam fetch_state_t FIRST = REQ;
   logic unused_cfg;
   assign unused_cfg = ^{flush, buf_wr, (BUF_ENTRIES != 0)};
`endif

   always_comb begin
      state_d   = state_q;
      load      = 1'b0;
      load_data = imem_rdata;
      req       = 1'b0;
      buf_wr    = 1'b0;
      case (state_q)
         IDLE: state_d = FIRST;
`ifdef FETCH_BUFFER_EN
         LOOKUP: begin
            if (misaligned(pc[1:0]))
               state_d = FAULT;
            else if (buf_hit) begin
               load      = 1'b1;
               load_data = buf_data;
               state_d   = EXEC;
            end else
               state_d = REQ;
         end
`endif
         // pc is only stable once the datapath has advanced, so the alignment
         // check lives here rather than on the way out of EXEC.
         REQ: begin
            if (misaligned(pc[1:0]))
               state_d = FAULT;
            else begin
               req = 1'b1;
               if (imem_gnt) state_d = WAIT;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               load    = 1'b1;
               buf_wr  = !flush;
               state_d = EXEC;
            end
         end
         EXEC:    state_d = FIRST;
         FAULT:   state_d = FAULT;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         instr   <= NOP_INSTR;
         enable  <= 1'b0;
      end else begin
         state_q <= state_d;
         enable  <= load;
         if (load) instr <= load_data;
      end
   end

   assign imem_req  = req;
   assign imem_addr = req ? pc : RESET_PC;
   assign fault     = (state_q == FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;
   localparam logic [31:0] RPC = 32'h0040_0000;
`ifdef FETCH_BUFFER_EN
   localparam int MIN_GAP = 2;
`else
   localparam int MIN_GAP = 3;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] pc = RPC;
   logic [31:0] instr, imem_addr;
   logic        enable, imem_req, fault;
   logic        imem_gnt, imem_rvalid, flush;
   logic [31:0] imem_rdata;

   // memory model outputs and manual overrides
   logic        auto_mem = 1'b1;
   logic        a_gnt = 1'b0, a_rv = 1'b0, a_flush = 1'b0;
   logic [31:0] a_rdata = '0;
   logic        man_gnt = 1'b0, man_rv = 1'b0, t_flush = 1'b0;
   logic [31:0] man_rdata = '0;
   assign imem_gnt    = auto_mem ? a_gnt : man_gnt;
   assign imem_rvalid = auto_mem ? a_rv  : man_rv;
   assign imem_rdata  = auto_mem ? a_rdata : man_rdata;
   assign flush       = a_flush | t_flush;

   int gdel = 0, rdel = 0;
   bit stray = 0, flush_once = 0;
   int grants = 0, g08 = 0;
   int mode = 0;
   int cyc = 0;
   int checks = 0, errors = 0;
   logic [31:0] exp_q[$];

   fetch_unit dut (
      .clk(clk), .reset(reset), .pc(pc), .instr(instr), .enable(enable),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .flush(flush),
      .fault(fault)
   );

   always #5 clk = ~clk;
   initial forever begin @(posedge clk); cyc++; end

   // Instruction memory contents
   function automatic logic [31:0] memword(input logic [31:0] a);
      if (a == 32'h0040_0000) return 32'h2008_0005;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   // Datapath program flow: what pc becomes after an executed instruction
   function automatic logic [31:0] next_pc(input logic [31:0] cur);
      logic [9:0] r;
      case (mode)
         0: return cur;
         1: return cur + 32'd4;
         2: begin r = 10'($urandom); return {20'h00400, r, 2'b00}; end
         3: return (cur == 32'h0040_0000) ? 32'h0040_0004 : 32'h0040_0000;
         default: return (cur == 32'h0040_0008) ? 32'h0040_0000 : cur + 32'd4;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Datapath: advance pc after each executed instruction; expect its word next.
   initial forever begin
      @(negedge clk);
      if (reset && enable) begin
         pc = next_pc(pc);
         exp_q.push_back(memword(pc));
      end
   end

   // Memory: one outstanding request, configurable grant/response delays.
   initial begin
      bit busy = 0, counting = 0;
      int g_cnt = 0, rv_cnt = 0;
      logic [31:0] gaddr = '0;
      forever begin
         @(negedge clk);
         a_gnt = 0; a_rv = 0; a_flush = 0;
         if (!reset) begin
            busy = 0; counting = 0;
         end else if (auto_mem) begin
            if (busy) begin
               if (rv_cnt == 0) begin
                  a_rv = 1; a_rdata = memword(gaddr); busy = 0;
                  if (flush_once && gaddr == 32'h0040_0008) begin
                     a_flush = 1; flush_once = 0;
                  end
               end else rv_cnt--;
            end else if (imem_req) begin
               if (!counting) begin
                  g_cnt = (gdel < 0) ? int'($urandom_range(0, 3)) : gdel;
                  counting = 1;
               end
               if (g_cnt == 0) begin
                  a_gnt = 1; gaddr = imem_addr; busy = 1; counting = 0;
                  rv_cnt = (rdel < 0) ? int'($urandom_range(0, 3)) : rdel;
                  grants++;
                  if (imem_addr == 32'h0040_0008) g08++;
               end else g_cnt--;
            end else if (stray && $urandom_range(0, 3) == 0) begin
               a_rv = 1; a_rdata = $urandom;
            end
         end
      end
   end

   // Monitor: scoreboard pop on every enable plus protocol checks.
   initial begin
      logic [31:0] e;
      int last_en = -1;
      bit prev_en = 0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            last_en = -1; prev_en = 0;
         end else begin
            if (imem_req) chk("req_addr", imem_addr, pc);
            else          chk("idle_addr", imem_addr, RPC);
            if (fault) chk("fault_quiet", {30'b0, imem_req, enable}, 32'd0);
            if (enable) begin
               chk("en_pulse", {31'b0, prev_en}, 32'd0);
               if (last_en >= 0) chk("en_gap", {31'b0, (cyc - last_en) >= MIN_GAP}, 32'd1);
               last_en = cyc;
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_enable: got instr %h expected no enable", instr);
               end else begin
                  e = exp_q.pop_front();
                  chk("instr", instr, e);
               end
            end
            prev_en = enable;
         end
      end
   end

   task automatic wait_en(input int maxc, input string nm);
      bit ok = 0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         if (enable) begin ok = 1; break; end
      end
      chk(nm, {31'b0, ok}, 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, g0, nreq;
      bit en_seen, found;
      logic [31:0] a0;

      // Reset values
      repeat (3) @(negedge clk);
      #1;
      chk("rst_instr", instr, 32'h0);
      chk("rst_enable", {31'b0, enable}, 32'd0);
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, RPC);
      chk("rst_fault", {31'b0, fault}, 32'd0);

      // Basic fetch at RESET_PC, immediate grant, response next cycle
      @(negedge clk);
      exp_q.push_back(memword(pc));
      reset = 1;
      @(negedge clk);
`ifdef FETCH_BUFFER_EN
      @(negedge clk);
`endif
      chk("t1_req", {31'b0, imem_req}, 32'd1);
      chk("t1_addr", imem_addr, 32'h0040_0000);
      wait_en(20, "t1_en0");
      chk("t1_instr", instr, 32'h2008_0005);
      t0 = cyc;
      wait_en(20, "t1_en1");
`ifdef FETCH_BUFFER_EN
      chk("t1_gap", cyc - t0, 32'd2);
`else
      chk("t1_gap", cyc - t0, 32'd3);
`endif
      mode = 1;
      t0 = cyc;
      wait_en(20, "t1_en2");
`ifdef FETCH_BUFFER_EN
      chk("t1_gap2", cyc - t0, 32'd2);
`else
      chk("t1_gap2", cyc - t0, 32'd3);
`endif

      // Grant withheld three cycles
      gdel = 3;
      nreq = 0; a0 = '0; en_seen = 0;
      for (int i = 0; i < 15 && !en_seen; i++) begin
         @(negedge clk);
         if (imem_req) begin
            if (nreq == 0) a0 = imem_addr;
            else chk("t3_addr_stable", imem_addr, a0);
            nreq++;
         end
         if (enable) en_seen = 1;
      end
      chk("t3_req_cycles", nreq, 32'd4);
      chk("t3_enable", {31'b0, en_seen}, 32'd1);
      gdel = 0;

      // Reset while waiting for a response; stale rvalid after release
      auto_mem = 0;
      found = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (imem_req) begin found = 1; break; end
      end
      chk("t4_req_seen", {31'b0, found}, 32'd1);
      man_gnt = 1;
      @(negedge clk);
      man_gnt = 0;
      #2 reset = 0;
      exp_q.delete();
      #1;
      chk("t4_rst_instr", instr, 32'h0);
      chk("t4_rst_enable", {31'b0, enable}, 32'd0);
      chk("t4_rst_req", {31'b0, imem_req}, 32'd0);
      chk("t4_rst_addr", imem_addr, RPC);
      @(negedge clk);
      reset = 1;
      @(negedge clk);
      man_rv = 1; man_rdata = 32'hDEAD_BEEF;
      exp_q.push_back(memword(pc));
      @(negedge clk);
      man_rv = 0;
      chk("t4_stale_enable", {31'b0, enable}, 32'd0);
      chk("t4_stale_instr", instr, 32'h0);
      found = imem_req;
      for (int i = 0; i < 4 && !found; i++) begin
         @(negedge clk);
         found = imem_req;
      end
      chk("t4_fresh_req", {31'b0, found}, 32'd1);
      chk("t4_fresh_addr", imem_addr, pc);
      auto_mem = 1;
      wait_en(20, "t4_refetch");

      // Misaligned pc
      reset = 0;
      exp_q.delete();
      pc = 32'h0040_0002;
      @(negedge clk);
      reset = 1;
      nreq = 0; en_seen = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (imem_req) nreq++;
         if (enable) en_seen = 1;
      end
      chk("t5_no_req", nreq, 32'd0);
      chk("t5_no_enable", {31'b0, en_seen}, 32'd0);
      chk("t5_fault", {31'b0, fault}, 32'd1);

      // Randomized pc flow, delays and stray responses
      reset = 0;
      exp_q.delete();
      pc = 32'h0040_0100;
      exp_q.push_back(memword(pc));
      mode = 2; gdel = -1; rdel = -1; stray = 1;
      @(negedge clk);
      reset = 1;
      g0 = grants;
      for (int n = 0; n < 40; n++) wait_en(40, "t6_en");
`ifndef FETCH_BUFFER_EN
      chk("t6_one_req_per_instr", grants - g0, 32'd40);
`endif
      stray = 0; gdel = 0; rdel = 0;

`ifdef FETCH_BUFFER_EN
      // Two-instruction loop served from the buffer, then a flush
      reset = 0;
      exp_q.delete();
      pc = RPC; mode = 3;
      exp_q.push_back(memword(pc));
      @(negedge clk);
      reset = 1;
      g0 = grants;
      for (int n = 0; n < 5; n++) wait_en(20, "t7_en");
      t0 = cyc;
      wait_en(20, "t7_en");
      chk("t7_hit_gap", cyc - t0, 32'd2);
      chk("t7_first_pass_reqs", grants - g0, 32'd2);
      t_flush = 1;
      @(negedge clk);
      t_flush = 0;
      g0 = grants;
      for (int n = 0; n < 4; n++) wait_en(20, "t7_post_flush");
      chk("t7_refetch_reqs", grants - g0, 32'd2);

      // Flush on the response cycle of 0x0040_0008
      reset = 0;
      exp_q.delete();
      pc = RPC; mode = 4; flush_once = 1;
      exp_q.push_back(memword(pc));
      @(negedge clk);
      reset = 1;
      g0 = grants; nreq = g08;
      for (int n = 0; n < 9; n++) wait_en(20, "t8_en");
      chk("t8_reqs_08", g08 - nreq, 32'd2);
      chk("t8_total_reqs", grants - g0, 32'd6);
`endif

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
